wb_queue: RTL and testbench

Writeback queue that sits in front of the register file's write port and drives it. Execute-side producers (ALU, load unit, mul/div) push register results through a valid/ready handshake. The block buffers them in order and retires one per cycle onto the register-file write port. It also returns forwarding data for any read port whose register still has a queued, unretired write, so decode never reads stale data.

---
 rtl/wb_queue.sv | 117 +++++++++++
 tb/tb_wb_queue.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Writeback queue in front of the register-file write port: buffers producer
// results in order, retires one per cycle, and forwards queued data to two read ports.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_num,
  input  logic [31:0]   in_data,
  output logic [4:0]    wr_num,
  output logic [31:0]   wr_data,
  output logic          wr_en,
  input  logic [4:0]    rd0_num,
  output logic          rd0_hit,
  output logic [31:0]   rd0_fwd,
  input  logic [4:0]    rd1_num,
  output logic          rd1_hit,
  output logic [31:0]   rd1_fwd,
  output logic [PW:0]   count
);

  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);
  localparam int          NPORTS     = 2;

  logic [DEPTH-1:0] valid_reg;
  logic [4:0]       num_reg  [DEPTH];
  logic [31:0]      data_reg [DEPTH];
  logic [PW-1:0]    head_reg;
  logic [PW-1:0]    tail_reg;
  logic [PW:0]      count_reg;
  logic [PW:0]      count_next;

  logic push;
  logic pop;

  assign in_ready = (count_reg != FULL_COUNT);
  assign pop      = (count_reg != '0);
  // register 0 is hardwired, so such results are acknowledged but never stored
  assign push     = in_valid && in_ready && (in_num != 5'd0);

  assign wr_en   = pop;
  assign wr_num  = pop ? num_reg[head_reg]  : 5'd0;
  assign wr_data = pop ? data_reg[head_reg] : 32'd0;
  assign count   = count_reg;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      valid_reg <= '0;
    end else begin
      // push and pop never target the same slot: pop needs count>0, push needs count<DEPTH
      if (pop) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg            <= head_reg + 1'b1;
      end
      if (push) begin
        valid_reg[tail_reg] <= 1'b1;
        num_reg[tail_reg]   <= in_num;
        data_reg[tail_reg]  <= in_data;
        tail_reg            <= tail_reg + 1'b1;
      end
      count_reg <= count_next;
    end
  end

  logic [4:0]  rd_num  [NPORTS];
  logic        rd_hit  [NPORTS];
  logic [31:0] rd_fwd  [NPORTS];

  assign rd_num[0] = rd0_num;
  assign rd_num[1] = rd1_num;
  assign rd0_hit   = rd_hit[0];
  assign rd0_fwd   = rd_fwd[0];
  assign rd1_hit   = rd_hit[1];
  assign rd1_fwd   = rd_fwd[1];

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_port
      logic [DEPTH-1:0] match;
      genvar ge;
      for (ge = 0; ge < DEPTH; ge++) begin : g_entry
        assign match[ge] = valid_reg[ge] && (num_reg[ge] == rd_num[gi]);
      end

      // walk oldest to youngest so the last match wins
      always_comb begin
        logic [PW-1:0] idx;
        rd_hit[gi] = 1'b0;
        rd_fwd[gi] = 32'd0;
        idx        = head_reg;
        for (int k = 0; k < DEPTH; k++) begin
          idx = head_reg + PW'(k);
          if (match[idx] && (rd_num[gi] != 5'd0)) begin
            rd_hit[gi] = 1'b1;
            rd_fwd[gi] = data_reg[idx];
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_wb_queue.sv
// Randomized scoreboard bench for wb_queue: a queue-based reference model predicts
// occupancy, forwarding and the register-write order.
module tb_wb_queue;
  localparam int DEPTH = 4;
  localparam int PW    = 2;

  logic        clk = 0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_num;
  logic [31:0] in_data;
  logic [4:0]  wr_num;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [4:0]  rd0_num;
  logic        rd0_hit;
  logic [31:0] rd0_fwd;
  logic [4:0]  rd1_num;
  logic        rd1_hit;
  logic [31:0] rd1_fwd;
  logic [PW:0] count;

  wb_queue #(.DEPTH(DEPTH), .PW(PW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num), .in_data(in_data),
    .wr_num(wr_num), .wr_data(wr_data), .wr_en(wr_en),
    .rd0_num(rd0_num), .rd0_hit(rd0_hit), .rd0_fwd(rd0_fwd),
    .rd1_num(rd1_num), .rd1_hit(rd1_hit), .rd1_fwd(rd1_fwd),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  num;
    logic [31:0] data;
  } entry_t;

  entry_t mq[$];      // contents of the queue as the model sees it
  entry_t exp_wr[$];  // register writes still expected, in order
  int     errors = 0;
  int     checks = 0;
  int     writes_seen = 0;
  bit     mon_en = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void lookup(input logic [4:0] n, output logic hit, output logic [31:0] fwd);
    hit = 0;
    fwd = 0;
    if (n != 0)
      foreach (mq[i])
        if (mq[i].num == n) begin
          hit = 1;
          fwd = mq[i].data;
        end
  endfunction

  // one clock: drive inputs, let the edge happen, advance the model
  task automatic cycle(input bit v, input logic [4:0] n, input logic [31:0] d,
                       input logic [4:0] r0, input logic [4:0] r1, input bit rst);
    entry_t e;
    bit     can_push;
    reset = rst; in_valid = v; in_num = n; in_data = d; rd0_num = r0; rd1_num = r1;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      exp_wr.delete();
    end else begin
      can_push = (mq.size() < DEPTH);
      if (mq.size() != 0) void'(mq.pop_front());
      if (v && can_push && n != 0) begin
        e.num = n; e.data = d;
        mq.push_back(e);
        exp_wr.push_back(e);
      end
    end
    $display("cyc rst=%0d v=%0d num=%0d data=%08h model_count=%0d", rst, v, n, d, mq.size());
    #1;
  endtask

  // monitor: checks outputs mid-cycle and consumes expected writes
  always @(negedge clk) begin
    logic        h;
    logic [31:0] f;
    entry_t      e;
    if (mon_en) begin
      check("count", 32'(count), 32'(mq.size()));
      check("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
      check("wr_en", 32'(wr_en), 32'(mq.size() != 0));
      lookup(rd0_num, h, f);
      check("rd0_hit", 32'(rd0_hit), 32'(h));
      check("rd0_fwd", rd0_fwd, f);
      lookup(rd1_num, h, f);
      check("rd1_hit", 32'(rd1_hit), 32'(h));
      check("rd1_fwd", rd1_fwd, f);
      if (wr_en) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write", 32'(wr_num), 32'hFFFF_FFFF);
        end else begin
          e = exp_wr.pop_front();
          check("wr_num", 32'(wr_num), 32'(e.num));
          check("wr_data", wr_data, e.data);
          writes_seen++;
        end
      end else begin
        check("wr_num_idle", 32'(wr_num), 0);
        check("wr_data_idle", wr_data, 0);
      end
    end
  end

  initial begin
    cycle(0, 0, 0, 5, 0, 1);
    mon_en = 1;
    cycle(0, 0, 0, 5, 0, 1);
    cycle(0, 0, 0, 5, 0, 0);

    // single push into empty queue
    cycle(1, 8, 32'hAA, 8, 0, 0);
    cycle(0, 0, 0, 8, 0, 0);
    cycle(0, 0, 0, 8, 0, 0);

    // same register twice, younger forwarded
    cycle(1, 3, 32'h11, 0, 3, 0);
    cycle(1, 3, 32'h22, 0, 3, 0);
    cycle(0, 0, 0, 0, 3, 0);
    cycle(0, 0, 0, 0, 3, 0);
    cycle(0, 0, 0, 0, 3, 0);

    // continuous stream, push+pop every edge
    for (int i = 1; i <= 7; i++) cycle(1, 5'(i), 32'(i * 16'h101), 5'(i), 5'(i - 1), 0);
    cycle(0, 0, 0, 7, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // register 0 is dropped
    cycle(1, 0, 32'hDEAD, 0, 0, 0);
    check("r0_in_ready", 32'(in_ready), 1);
    cycle(0, 0, 0, 0, 0, 0);

    // reset with a write pending discards it
    cycle(1, 9, 32'h99, 9, 9, 0);
    cycle(1, 10, 32'h1010, 9, 10, 1);
    cycle(0, 0, 0, 9, 10, 0);
    cycle(0, 0, 0, 9, 10, 0);

    // randomized traffic on a small register range to force collisions
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom_range(0, 49) == 0);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0);

    check("drain_empty", 32'(exp_wr.size()), 0);
    check("writes_seen_nonzero", 32'(writes_seen > 50), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1);
  end
endmodule
